// File: rtl/bbq_draw_pkg.sv
// Shared constants and state encoding for the steak sprite draw scheduler.
// Pure declarations; no logic, no latency.
package bbq_draw_pkg;
  localparam int NUM_STEAKS = 6;
  localparam int IDX_W      = 3;
  localparam int SPRITE_W   = 16;
  localparam int SPRITE_H   = 15;
  localparam int OFF_W      = 4;

  typedef enum logic [1:0] {IDLE, GRANT, DRAW, DONE} draw_state_t;
endpackage

// File: rtl/steak_draw_scheduler_rr_pick.sv
// Round-robin priority encoder: first set req bit after 'last', wrapping at N-1.
// Purely combinational, zero latency; no backpressure.
module rr_pick #(
  parameter int N = 6,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         valid,
  output logic [W-1:0] idx
);
  logic [W:0] sum;

  // Walk from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int i = N; i >= 1; i--) begin
      sum = {1'b0, last} + (W+1)'(i);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      if (req[sum[W-1:0]]) begin
        valid = 1'b1;
        idx   = sum[W-1:0];
      end
    end
  end
endmodule

// File: rtl/steak_draw_scheduler.sv
// Dirty-flag round-robin scheduler sharing the VGA plot port among steak sprites.
// Per sprite: IDLE pick, GRANT, one DRAW cycle per accepted pixel, DONE; stalls on vga_ready=0. Urgent lane: BBQ_URGENT_EN.
module steak_draw_scheduler
  import bbq_draw_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_STEAKS-1:0] dirty,
  input  logic                  force_all,
`ifdef BBQ_URGENT_EN
  input  logic [NUM_STEAKS-1:0] urgent,
`endif
  input  logic                  vga_ready,
  output logic                  plot,
  output logic [IDX_W-1:0]      sel,
  output logic [OFF_W-1:0]      off_x,
  output logic [OFF_W-1:0]      off_y,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_STEAKS-1:0] pending
);
  draw_state_t           state_q, state_d;
  logic [IDX_W-1:0]      sel_q, sel_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [OFF_W-1:0]      off_x_q, off_x_d;
  logic [OFF_W-1:0]      off_y_q, off_y_d;
  logic [NUM_STEAKS-1:0] pending_q, pending_d;
  logic [NUM_STEAKS-1:0] clear_mask;
  logic                  pick_vld;
  logic [IDX_W-1:0]      pick_idx;

  rr_pick #(.N(NUM_STEAKS), .W(IDX_W)) u_rr_pick (
    .req   (pending_q),
    .last  (last_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

`ifdef BBQ_URGENT_EN
  logic [NUM_STEAKS-1:0] urgent_q, urgent_d;
  logic                  urg_vld;
  logic [IDX_W-1:0]      urg_idx;

  always_comb begin
    urg_vld = |urgent_q;
    urg_idx = '0;
    for (int i = NUM_STEAKS-1; i >= 0; i--) begin
      if (urgent_q[i]) urg_idx = IDX_W'(i);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    off_x_d    = off_x_q;
    off_y_d    = off_y_q;
    clear_mask = '0;
    case (state_q)
      IDLE: begin
`ifdef BBQ_URGENT_EN
        // Urgent grants bypass the rotation so ordinary fairness is untouched.
        if (urg_vld) begin
          sel_d               = urg_idx;
          clear_mask[urg_idx] = 1'b1;
          state_d             = GRANT;
        end else
`endif
        if (pick_vld) begin
          sel_d                = pick_idx;
          last_d               = pick_idx;
          clear_mask[pick_idx] = 1'b1;
          state_d              = GRANT;
        end
      end
      GRANT: begin
        off_x_d = '0;
        off_y_d = '0;
        state_d = DRAW;
      end
      DRAW: begin
        if (vga_ready) begin
          if (off_x_q == OFF_W'(SPRITE_W-1)) begin
            off_x_d = '0;
            if (off_y_q == OFF_W'(SPRITE_H-1)) begin
              off_y_d = '0;
              state_d = DONE;
            end else begin
              off_y_d = off_y_q + 1'b1;
            end
          end else begin
            off_x_d = off_x_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Set beats clear, so a re-dirtied steak being granted is queued again.
    pending_d = (pending_q & ~clear_mask) | dirty | {NUM_STEAKS{force_all}};
`ifdef BBQ_URGENT_EN
    urgent_d  = (urgent_q & ~clear_mask) | urgent;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      last_q    <= IDX_W'(NUM_STEAKS-1);
      off_x_q   <= '0;
      off_y_q   <= '0;
      pending_q <= '1;
`ifdef BBQ_URGENT_EN
      urgent_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      off_x_q   <= off_x_d;
      off_y_q   <= off_y_d;
      pending_q <= pending_d;
`ifdef BBQ_URGENT_EN
      urgent_q  <= urgent_d;
`endif
    end
  end

  assign plot    = (state_q == DRAW);
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign sel     = sel_q;
  assign off_x   = off_x_q;
  assign off_y   = off_y_q;
  assign pending = pending_q;
endmodule

// File: doc/steak_draw_scheduler.md
Name: steak_draw_scheduler

Overview:
- Shares the single VGA plot port among NUM_STEAKS steak graphics datapaths.
- Replaces the free-running pixel and index counters with a dirty-flag, round-robin, handshaked scheduler.
- A steak is redrawn only when its colours change, or on reset or force.
- Drives the top-level select mux (sel) and the per-sprite pixel offsets (off_x, off_y) that the datapaths add to their screen base.

Parameters:
- NUM_STEAKS, 6: number of requesters (steaks).
- IDX_W, 3: width of sel; must satisfy 2**IDX_W >= NUM_STEAKS.
- SPRITE_W, 16: sprite width in pixels.
- SPRITE_H, 15: sprite height in pixels.
- OFF_W, 4: width of off_x and off_y; must satisfy 2**OFF_W >= max(SPRITE_W, SPRITE_H).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous reset, active-low.
- dirty  in  NUM_STEAKS  per-steak redraw request; a 1-cycle pulse, or level (level is treated as repeated pulses).
- force_all  in  1  sets every dirty flag.
- vga_ready  in  1  VGA adapter accepts the current pixel this cycle.
- plot  out  1  pixel valid for sel/off_x/off_y.
- sel  out  IDX_W  index of the steak being drawn; feeds the colour/x/y mux.
- off_x  out  OFF_W  column offset within the sprite.
- off_y  out  OFF_W  row offset within the sprite.
- busy  out  1  high in GRANT, DRAW and DONE.
- done  out  1  1-cycle pulse when a sprite has finished.
- pending  out  NUM_STEAKS  current dirty flags (for debug and the game FSM).

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE; plot=0, sel=0, off_x=0, off_y=0, busy=0, done=0.
  - Round-robin pointer last=NUM_STEAKS-1, so steak 0 wins first.
  - pending=all ones, so the full scene is drawn once after reset.
  - Reset mid-draw aborts the sprite immediately; no done pulse.
- Flag update (registered, every cycle): pending_next = (pending & ~clear_mask) | dirty | {NUM_STEAKS{force_all}}.
  - Set wins over clear in the same cycle, so a steak re-dirtied while it is being granted is drawn again later.
- IDLE:
  - If pending==0, stay in IDLE.
  - Otherwise pick the first set bit searching from last+1 upward, wrapping at NUM_STEAKS-1 to 0. Latch it into sel and last, clear its flag, go to GRANT.
- GRANT (1 cycle): off_x=0, off_y=0, plot=0. Next state is DRAW. This gives the datapaths one cycle to settle colours for the new sel.
- DRAW:
  - plot=1. Offsets advance only on plot&&vga_ready (the handshake).
  - off_x increments; at SPRITE_W-1 it wraps to 0 and off_y increments.
  - Acceptance at (SPRITE_W-1, SPRITE_H-1) goes to DONE.
  - While vga_ready=0, all outputs hold stable.
- DONE (1 cycle): done=1, plot=0. Next state is IDLE.
- Cycle budget per sprite with vga_ready held high: 1 (IDLE pick) + 1 (GRANT) + SPRITE_W*SPRITE_H (240 by default) + 1 (DONE) = 243 cycles.
- dirty for the steak currently in DRAW re-sets its flag. The current sprite completes uninterrupted, and the steak is eligible again after the other pending steaks in round-robin order.
- sel, off_x and off_y are registered. No combinational path exists from vga_ready to plot.
- Dirty indices >= NUM_STEAKS do not exist. Unused sel encodings are never produced.

Optional Feature:
- Macro: BBQ_URGENT_EN.
- With the macro defined:
  - Adds input urgent[NUM_STEAKS], registered into its own flags alongside pending.
  - In IDLE, any set urgent flag is served before ordinary pending, lowest index first, without updating last.
  - Granting clears both the urgent and pending bits for that steak.
  - Used for steaks about to burn.
- Without the macro: the port is absent and arbitration is pure round-robin.

Decomposition:
- Shared package bbq_draw_pkg holds:
  - constants NUM_STEAKS, SPRITE_W, SPRITE_H, IDX_W, OFF_W;
  - enum draw_state_t {IDLE, GRANT, DRAW, DONE}.
- One sub-module: rr_pick.
  - Purely combinational round-robin priority encoder.
  - Inputs: req, last. Outputs: valid, idx.
  - Instantiated once; reusable by future arbiters (e.g. the audio cue arbiter).

Test Plan:
- Reset release with vga_ready=1, no dirty: sel goes 0,1,2,3,4,5 in order; 240 plot cycles each; 6 done pulses; then pending=0 and busy=0.
- Idle, pulse dirty=6'b000100: sel=2 exactly 2 cycles later (GRANT cycle, then DRAW); last plot at off_x=15, off_y=14; done after 243 cycles total.
- During steak 2, toggle vga_ready 0/1 each cycle: offsets advance only on accepted cycles; still exactly 240 accepted pixels; sel stable throughout.
- With last=3, pulse dirty=6'b100011: service order is 5, 0, 1.
- During DRAW of steak 4, pulse dirty[4]: steak 4 completes; pending[4]=1 afterwards; steak 4 is redrawn after the other pending steaks.
- Assert resetn=0 mid-DRAW (off_y=7): next cycle plot=0, no done pulse, pending=all ones; redraw restarts at steak 0.
